// File: rtl/ctr_block_sequencer.sv
// AES-256 CTR block sequencer: walks one counter block at a time through the
// AES core, XORs the keystream with input text and streams masked results out.
module ctr_block_sequencer #(
  parameter int unsigned CTR_WIDTH = 128,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [255:0]     key_i,
  input  logic [127:0]     iv_i,
  input  logic [CNT_W-1:0] num_blocks_i,
  input  logic [3:0]       last_bytes_i,
  input  logic [127:0]     in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [127:0]     out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             aes_start_o,
  output logic [255:0]     aes_key_o,
  output logic [127:0]     aes_block_in_o,
  input  logic             aes_done_i,
  input  logic [127:0]     aes_block_out_i,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_XOR, S_OUT, S_DONE
  } state_t;

  // Only the low CTR_WIDTH counter bits take part in the increment.
  localparam logic [127:0] CTR_MASK =
    (CTR_WIDTH >= 128) ? '1 : ((128'd1 << CTR_WIDTH) - 128'd1);

  state_t           state_q, state_d;
  logic [255:0]     key_q, key_d;
  logic [127:0]     ctr_q, ctr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [3:0]       last_q, last_d;
  logic [127:0]     ks_q, ks_d;
  logic [127:0]     out_q, out_d;
  logic [127:0]     byte_mask;
  logic [127:0]     ctr_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      ctr_q   <= '0;
      rem_q   <= '0;
      last_q  <= '0;
      ks_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ctr_q   <= ctr_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      ks_q    <= ks_d;
      out_q   <= out_d;
    end
  end

  // Final-block mask: byte i (bits [127-8i -: 8]) survives only if i < last_bytes.
  always_comb begin
    byte_mask = '1;
    if ((rem_q == CNT_W'(1)) && (last_q != 4'd0)) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (i >= {28'd0, last_q}) byte_mask[127 - 8*i -: 8] = 8'h00;
      end
    end
  end

  assign ctr_inc = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    ctr_d   = ctr_q;
    rem_d   = rem_q;
    last_d  = last_q;
    ks_d    = ks_q;
    out_d   = out_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          key_d   = key_i;
          ctr_d   = iv_i;
          rem_d   = num_blocks_i;
          last_d  = last_bytes_i;
          state_d = (num_blocks_i == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (aes_done_i) begin
          ks_d    = aes_block_out_i;
          state_d = S_XOR;
        end
      end
      S_XOR: begin
        if (in_valid_i) begin
          out_d   = (in_data_i ^ ks_q) & byte_mask;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) begin
          ctr_d   = ctr_inc;
          rem_d   = rem_q - CNT_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o     = (state_q == S_XOR);
  assign out_valid_o    = (state_q == S_OUT);
  assign aes_start_o    = (state_q == S_REQ);
  assign done_o         = (state_q == S_DONE);
  assign busy_o         = (state_q != S_IDLE);
  assign out_data_o     = out_q;
  assign aes_key_o      = key_q;
  assign aes_block_in_o = ctr_q;

endmodule
